// File: rtl/match_game_ctrl_pkg.sv
// Shared definitions for the match-card game slice: the EMPTY card code,
// the controller state encoding and a constant clog2 helper used to size
// ports in the controller, map generator and renderer.
package match_game_ctrl_pkg;

  // A card code of all zeros marks a removed (empty) grid position.
  localparam int EMPTY_BLOCK = 0;

  // Controller states; the numeric codes are visible on the state output.
  typedef enum logic [2:0] {
    ST_GEN    = 3'd0,
    ST_IDLE   = 3'd1,
    ST_SELECT = 3'd2,
    ST_REVEAL = 3'd3,
    ST_EVAL   = 3'd4,
    ST_FINISH = 3'd5
  } state_t;

  // Ceiling log2, never smaller than 1 so every derived field has a bit.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    if (result < 1) result = 1;
    return result;
  endfunction

endpackage

// File: rtl/match_game_ctrl_if.sv
// Map exchange bundle between the game controller and the map generator /
// renderer side.
//   inputMap    generator -> controller  freshly generated card map
//   finishedGen generator -> controller  map generation complete
//   mapReset    controller -> generator  request a new map
//   logicMap    controller -> renderer   live card map
// master: controller side, slave: generator/renderer side.
interface match_game_ctrl_if #(
  parameter int MAP_BITS = 48
);

  logic [MAP_BITS-1:0] inputMap;
  logic                finishedGen;
  logic                mapReset;
  logic [MAP_BITS-1:0] logicMap;

  modport master (
    input  inputMap,
    input  finishedGen,
    output mapReset,
    output logicMap
  );

  modport slave (
    output inputMap,
    output finishedGen,
    input  mapReset,
    input  logicMap
  );

endinterface

// File: rtl/match_game_ctrl_btn_debounce.sv
// Button debouncer: samples a raw button on each shared divider tick into a
// 3-sample history and emits a single-cycle press pulse, registered on the
// tick edge, when the two oldest samples read released-then-pressed.
//   clk, reset_n  clock / asynchronous active-low reset
//   tick_i        shared sample strobe (one cycle per divider period)
//   btn_i         raw button level
//   pulse_o       one-cycle press pulse
module btn_debounce (
  input  logic clk,
  input  logic reset_n,
  input  logic tick_i,
  input  logic btn_i,
  output logic pulse_o
);

  logic [2:0] samples_q, samples_d;
  logic       pulse_q, pulse_d;

  // After the shift, the two oldest samples are the current samples_q[1:0],
  // so the edge test looks at the pre-shift history.
  always_comb begin
    samples_d = samples_q;
    pulse_d   = 1'b0;
    if (tick_i) begin
      samples_d = {samples_q[1:0], btn_i};
      pulse_d   = ~samples_q[1] & samples_q[0];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      samples_q <= '0;
      pulse_q   <= 1'b0;
    end else begin
      samples_q <= samples_d;
      pulse_q   <= pulse_d;
    end
  end

  assign pulse_o = pulse_q;

endmodule

// File: rtl/match_game_ctrl.sv
// Match-card game controller. Loads a generated card map, moves a wrapping
// cursor from debounced buttons, collects MATCH_COUNT selections, shows them
// for REVEAL_CYCLES, then removes them if they all match. When the board is
// cleared it holds mapReset for FINISH_CYCLES and waits for a new map.
//   clk, reset_n            clock / asynchronous active-low reset
//   btnU/D/L/R/S            raw buttons (up, down, left, right, select)
//   mapBus                  map bundle (inputMap, finishedGen, mapReset, logicMap)
//   cursor                  cursor index (row*BLOCKS_WIDE + column)
//   selected                selected indices, slot k at [k*CW +: CW]
//   selectedCount           number of filled slots
//   removedCards            cards removed so far
//   moves                   completed reveal attempts (saturating)
//   state                   current FSM state code
module match_game_ctrl
  import match_game_ctrl_pkg::*;
#(
  parameter int BLOCKS_WIDE    = 4,
  parameter int BLOCKS_HIGH    = 4,
  parameter int BITS_PER_BLOCK = 3,
  parameter int MATCH_COUNT    = 2,
  parameter int REVEAL_CYCLES  = 10_000_000,
  parameter int FINISH_CYCLES  = 100_000_000,
  parameter int DEBOUNCE_BITS  = 17,
  localparam int N    = BLOCKS_WIDE * BLOCKS_HIGH,
  localparam int CW   = clog2(N),
  localparam int SCW  = clog2(MATCH_COUNT + 1),
  localparam int RCW  = clog2(N + 1),
  localparam int MAPW = N * BITS_PER_BLOCK
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      btnU,
  input  logic                      btnD,
  input  logic                      btnL,
  input  logic                      btnR,
  input  logic                      btnS,
  match_game_ctrl_if.master         mapBus,
  output logic [CW-1:0]             cursor,
  output logic [MATCH_COUNT*CW-1:0] selected,
  output logic [SCW-1:0]            selectedCount,
  output logic [RCW-1:0]            removedCards,
  output logic [15:0]               moves,
  output logic [2:0]                state
);

  localparam int COLW = clog2(BLOCKS_WIDE);
  localparam int ROWW = clog2(BLOCKS_HIGH);

  logic [DEBOUNCE_BITS-1:0] divCnt_q;
  logic                     sampleTick;
  logic pulseU, pulseD, pulseL, pulseR, pulseS;

  state_t                            state_q, state_d;
  logic [COLW-1:0]                   col_q, col_d;
  logic [ROWW-1:0]                   row_q, row_d;
  logic [MATCH_COUNT-1:0][CW-1:0]    selected_q, selected_d;
  logic [SCW-1:0]                    selCount_q, selCount_d;
  logic [RCW-1:0]                    removed_q, removed_d;
  logic [15:0]                       moves_q, moves_d;
  logic                              mapReset_q, mapReset_d;
  logic [MAPW-1:0]                   logicMap_q, logicMap_d;
  logic [31:0]                       timer_q, timer_d;

  logic [CW-1:0]             cursorIdx;
  logic [BITS_PER_BLOCK-1:0] curCard;
  logic                      alreadySel;
  logic                      allEqual;

  function automatic logic [BITS_PER_BLOCK-1:0] cardAt(input logic [MAPW-1:0] map,
                                                      input logic [CW-1:0]   idx);
    return map[int'(idx) * BITS_PER_BLOCK +: BITS_PER_BLOCK];
  endfunction

  // One free-running divider feeds all five debouncers so they sample together.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) divCnt_q <= '0;
    else          divCnt_q <= divCnt_q + DEBOUNCE_BITS'(1);
  end

  assign sampleTick = &divCnt_q;

  btn_debounce u_dbU (.clk(clk), .reset_n(reset_n), .tick_i(sampleTick), .btn_i(btnU), .pulse_o(pulseU));
  btn_debounce u_dbD (.clk(clk), .reset_n(reset_n), .tick_i(sampleTick), .btn_i(btnD), .pulse_o(pulseD));
  btn_debounce u_dbL (.clk(clk), .reset_n(reset_n), .tick_i(sampleTick), .btn_i(btnL), .pulse_o(pulseL));
  btn_debounce u_dbR (.clk(clk), .reset_n(reset_n), .tick_i(sampleTick), .btn_i(btnR), .pulse_o(pulseR));
  btn_debounce u_dbS (.clk(clk), .reset_n(reset_n), .tick_i(sampleTick), .btn_i(btnS), .pulse_o(pulseS));

  // The cursor is kept as row/column so wrapping is a compare, never a modulo.
  assign cursorIdx = CW'(int'(row_q) * BLOCKS_WIDE + int'(col_q));

  // Card under the cursor, duplicate-selection test over filled slots, and the
  // all-selected-cards-equal test used by EVAL.
  always_comb begin
    curCard    = cardAt(logicMap_q, cursorIdx);
    alreadySel = 1'b0;
    allEqual   = 1'b1;
    for (int k = 0; k < MATCH_COUNT; k++) begin
      if ((k < int'(selCount_q)) && (selected_q[k] == cursorIdx)) alreadySel = 1'b1;
      if (cardAt(logicMap_q, selected_q[k]) != cardAt(logicMap_q, selected_q[0])) allEqual = 1'b0;
    end
  end

  // Next-state logic. Button pulses are only consumed in IDLE; in every other
  // state they are simply ignored and therefore lost.
  always_comb begin
    state_d    = state_q;
    col_d      = col_q;
    row_d      = row_q;
    selected_d = selected_q;
    selCount_d = selCount_q;
    removed_d  = removed_q;
    moves_d    = moves_q;
    mapReset_d = mapReset_q;
    logicMap_d = logicMap_q;
    timer_d    = timer_q;

    case (state_q)
      ST_GEN: begin
        if (mapBus.finishedGen) begin
          logicMap_d = mapBus.inputMap;
          removed_d  = '0;
          selCount_d = '0;
          col_d      = '0;
          row_d      = '0;
          moves_d    = '0;
          state_d    = ST_IDLE;
        end
      end

      ST_IDLE: begin
        if (pulseS)      state_d = ST_SELECT;
        else if (pulseU) row_d = (row_q == '0) ? ROWW'(BLOCKS_HIGH - 1) : row_q - ROWW'(1);
        else if (pulseD) row_d = (row_q == ROWW'(BLOCKS_HIGH - 1)) ? '0 : row_q + ROWW'(1);
        else if (pulseL) col_d = (col_q == '0) ? COLW'(BLOCKS_WIDE - 1) : col_q - COLW'(1);
        else if (pulseR) col_d = (col_q == COLW'(BLOCKS_WIDE - 1)) ? '0 : col_q + COLW'(1);
      end

      ST_SELECT: begin
        state_d = ST_IDLE;
        if ((curCard != BITS_PER_BLOCK'(EMPTY_BLOCK)) && !alreadySel) begin
          for (int k = 0; k < MATCH_COUNT; k++) begin
            if (k == int'(selCount_q)) selected_d[k] = cursorIdx;
          end
          selCount_d = selCount_q + SCW'(1);
          if (selCount_q == SCW'(MATCH_COUNT - 1)) begin
            state_d = ST_REVEAL;
            timer_d = '0;
          end
        end
      end

      ST_REVEAL: begin
        if (timer_q == 32'(REVEAL_CYCLES - 1)) state_d = ST_EVAL;
        else                                   timer_d = timer_q + 32'd1;
      end

      ST_EVAL: begin
        moves_d    = (moves_q == 16'hFFFF) ? moves_q : moves_q + 16'd1;
        selCount_d = '0;
        state_d    = ST_IDLE;
        if (allEqual) begin
          for (int k = 0; k < MATCH_COUNT; k++) begin
            logicMap_d[int'(selected_q[k]) * BITS_PER_BLOCK +: BITS_PER_BLOCK] =
              BITS_PER_BLOCK'(EMPTY_BLOCK);
          end
          removed_d = removed_q + RCW'(MATCH_COUNT);
          if (removed_q == RCW'(N - MATCH_COUNT)) begin
            state_d    = ST_FINISH;
            timer_d    = '0;
            mapReset_d = 1'b1;
          end
        end
      end

      ST_FINISH: begin
        if (timer_q == 32'(FINISH_CYCLES - 1)) begin
          mapReset_d = 1'b0;
          state_d    = ST_GEN;
        end else begin
          timer_d = timer_q + 32'd1;
        end
      end

      default: state_d = ST_GEN;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_GEN;
      col_q      <= '0;
      row_q      <= '0;
      selected_q <= '0;
      selCount_q <= '0;
      removed_q  <= '0;
      moves_q    <= '0;
      mapReset_q <= 1'b0;
      logicMap_q <= '0;
      timer_q    <= '0;
    end else begin
      state_q    <= state_d;
      col_q      <= col_d;
      row_q      <= row_d;
      selected_q <= selected_d;
      selCount_q <= selCount_d;
      removed_q  <= removed_d;
      moves_q    <= moves_d;
      mapReset_q <= mapReset_d;
      logicMap_q <= logicMap_d;
      timer_q    <= timer_d;
    end
  end

  assign mapBus.mapReset = mapReset_q;
  assign mapBus.logicMap = logicMap_q;
  assign cursor          = cursorIdx;
  assign selected        = selected_q;
  assign selectedCount   = selCount_q;
  assign removedCards    = removed_q;
  assign moves           = moves_q;
  assign state           = state_q;

endmodule

// File: tb/tb_match_game_ctrl.sv
// Directed bench for match_game_ctrl: a 4x4 pair game (dutA) and a 5x3
// triple game (dutB), both with short reveal/finish times and a 4-cycle
// debounce sample period, driven through raw button presses.
module tb_match_game_ctrl;

  localparam logic [4:0] BU = 5'b10000;
  localparam logic [4:0] BD = 5'b01000;
  localparam logic [4:0] BL = 5'b00100;
  localparam logic [4:0] BR = 5'b00010;
  localparam logic [4:0] BS = 5'b00001;

  logic        clk;
  logic        reset_nA, reset_nB;
  logic [4:0]  btnA, btnB;
  logic [3:0]  cursorA, cursorB;
  logic [7:0]  selA;
  logic [11:0] selB;
  logic [1:0]  selCntA, selCntB;
  logic [4:0]  remA;
  logic [3:0]  remB;
  logic [15:0] movesA, movesB;
  logic [2:0]  stateA, stateB;

  logic [47:0] expMapA;
  logic [44:0] expMapB;
  int          expRow[2];
  int          expCol[2];
  int          assertCount = 0;
  int          failCount   = 0;

  int revealRunA = 0, lastRevealA = 0;
  int revealRunB = 0, lastRevealB = 0;
  int mapRunA    = 0, lastMapA    = 0;

  match_game_ctrl_if #(.MAP_BITS(48)) busA ();
  match_game_ctrl_if #(.MAP_BITS(45)) busB ();

  match_game_ctrl #(
    .BLOCKS_WIDE(4), .BLOCKS_HIGH(4), .BITS_PER_BLOCK(3), .MATCH_COUNT(2),
    .REVEAL_CYCLES(20), .FINISH_CYCLES(15), .DEBOUNCE_BITS(2)
  ) dutA (
    .clk(clk), .reset_n(reset_nA),
    .btnU(btnA[4]), .btnD(btnA[3]), .btnL(btnA[2]), .btnR(btnA[1]), .btnS(btnA[0]),
    .mapBus(busA), .cursor(cursorA), .selected(selA), .selectedCount(selCntA),
    .removedCards(remA), .moves(movesA), .state(stateA)
  );

  match_game_ctrl #(
    .BLOCKS_WIDE(5), .BLOCKS_HIGH(3), .BITS_PER_BLOCK(3), .MATCH_COUNT(3),
    .REVEAL_CYCLES(20), .FINISH_CYCLES(12), .DEBOUNCE_BITS(2)
  ) dutB (
    .clk(clk), .reset_n(reset_nB),
    .btnU(btnB[4]), .btnD(btnB[3]), .btnL(btnB[2]), .btnR(btnB[1]), .btnS(btnB[0]),
    .mapBus(busB), .cursor(cursorB), .selected(selB), .selectedCount(selCntB),
    .removedCards(remB), .moves(movesB), .state(stateB)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Length of the most recent contiguous REVEAL / mapReset stretch, in cycles.
  always @(posedge clk) begin
    if (stateA == 3'd3) revealRunA <= revealRunA + 1;
    else if (revealRunA != 0) begin lastRevealA <= revealRunA; revealRunA <= 0; end
    if (stateB == 3'd3) revealRunB <= revealRunB + 1;
    else if (revealRunB != 0) begin lastRevealB <= revealRunB; revealRunB <= 0; end
    if (busA.mapReset) mapRunA <= mapRunA + 1;
    else if (mapRunA != 0) begin lastMapA <= mapRunA; mapRunA <= 0; end
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    assertCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Hold the buttons for three sample ticks, then release for three.
  task automatic applyStimulus(input bit isB, input logic [4:0] btns);
    @(negedge clk);
    if (isB) btnB = btns; else btnA = btns;
    repeat (12) @(negedge clk);
    if (isB) btnB = '0; else btnA = '0;
    repeat (12) @(negedge clk);
  endtask

  task automatic waitState(input bit isB, input logic [2:0] target, input int budget,
                           input string tag);
    logic [2:0] st;
    int n;
    n  = 0;
    st = isB ? stateB : stateA;
    while (st !== target && n < budget) begin
      @(negedge clk);
      st = isB ? stateB : stateA;
      n++;
    end
    checkOutput(tag, 64'(st), 64'(target));
  endtask

  task automatic setExp(input bit isB, input int idx);
    int w;
    w = isB ? 5 : 4;
    expRow[isB] = idx / w;
    expCol[isB] = idx % w;
  endtask

  // Walk the cursor forward (down, then right) to a target using the bench's
  // own row/column model, then confirm the DUT landed there.
  task automatic navigate(input bit isB, input int target, input string tag);
    int w, h;
    w = isB ? 5 : 4;
    h = isB ? 3 : 4;
    while (expRow[isB] != target / w) begin
      applyStimulus(isB, BD);
      expRow[isB] = (expRow[isB] == h - 1) ? 0 : expRow[isB] + 1;
    end
    while (expCol[isB] != target % w) begin
      applyStimulus(isB, BR);
      expCol[isB] = (expCol[isB] == w - 1) ? 0 : expCol[isB] + 1;
    end
    checkOutput(tag, 64'(isB ? cursorB : cursorA), 64'(target));
  endtask

  task automatic loadMap(input bit isB);
    @(negedge clk);
    if (isB) busB.finishedGen = 1'b1; else busA.finishedGen = 1'b1;
    @(negedge clk);
    if (isB) busB.finishedGen = 1'b0; else busA.finishedGen = 1'b0;
  endtask

  initial begin
    int pairs[7];
    pairs = '{0, 2, 6, 8, 10, 12, 14};
    btnA = '0; btnB = '0;
    busA.finishedGen = 1'b0; busB.finishedGen = 1'b0;
    for (int i = 0; i < 16; i++) expMapA[i*3 +: 3] = 3'(((i / 2) % 7) + 1);
    for (int i = 0; i < 15; i++) expMapB[i*3 +: 3] = 3'((i / 3) + 1);
    busA.inputMap = expMapA;
    busB.inputMap = expMapB;
    reset_nA = 1'b0; reset_nB = 1'b0;
    repeat (4) @(negedge clk);

    checkOutput("A reset state", 64'(stateA), 64'd0);
    checkOutput("A reset cursor", 64'(cursorA), 64'd0);
    checkOutput("A reset moves", 64'(movesA), 64'd0);
    checkOutput("A reset mapReset", 64'(busA.mapReset), 64'd0);
    checkOutput("A reset logicMap", 64'(busA.logicMap), 64'd0);
    checkOutput("B reset selected", 64'(selB), 64'd0);
    reset_nA = 1'b1; reset_nB = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("A waits for map", 64'(stateA), 64'd0);

    // ---- 4x4 pair game ----
    loadMap(0);
    checkOutput("A loaded state", 64'(stateA), 64'd1);
    checkOutput("A loaded map", 64'(busA.logicMap), 64'(expMapA));
    applyStimulus(0, BU); checkOutput("A 0 up", 64'(cursorA), 64'd12);
    applyStimulus(0, BD); checkOutput("A 12 down", 64'(cursorA), 64'd0);
    applyStimulus(0, BL); checkOutput("A 0 left", 64'(cursorA), 64'd3);
    applyStimulus(0, BR); checkOutput("A 3 right", 64'(cursorA), 64'd0);
    setExp(0, 0);
    navigate(0, 5, "A goto 5");
    applyStimulus(0, BS);
    checkOutput("A sel5 count", 64'(selCntA), 64'd1);
    checkOutput("A sel5 slot0", 64'(selA[3:0]), 64'd5);
    checkOutput("A sel5 state", 64'(stateA), 64'd1);
    applyStimulus(0, BS);
    checkOutput("A sel5 twice count", 64'(selCntA), 64'd1);
    applyStimulus(0, BL); setExp(0, 4);
    checkOutput("A 5 left", 64'(cursorA), 64'd4);
    applyStimulus(0, BS);
    waitState(0, 3'd1, 60, "A match 4/5 done");
    repeat (2) @(negedge clk);
    expMapA[12 +: 3] = 3'd0; expMapA[15 +: 3] = 3'd0;
    checkOutput("A reveal length", 64'(lastRevealA), 64'd20);
    checkOutput("A match map", 64'(busA.logicMap), 64'(expMapA));
    checkOutput("A match removed", 64'(remA), 64'd2);
    checkOutput("A match moves", 64'(movesA), 64'd1);
    checkOutput("A match count", 64'(selCntA), 64'd0);
    checkOutput("A match slots", 64'(selA), 64'h45);
    applyStimulus(0, BS);
    checkOutput("A empty sel count", 64'(selCntA), 64'd0);
    checkOutput("A empty sel state", 64'(stateA), 64'd1);
    navigate(0, 6, "A goto 6");
    applyStimulus(0, BS);
    navigate(0, 10, "A goto 10");
    applyStimulus(0, BS);
    waitState(0, 3'd1, 60, "A mismatch done");
    checkOutput("A mismatch map", 64'(busA.logicMap), 64'(expMapA));
    checkOutput("A mismatch count", 64'(selCntA), 64'd0);
    checkOutput("A mismatch moves", 64'(movesA), 64'd2);
    checkOutput("A mismatch removed", 64'(remA), 64'd2);
    for (int i = 0; i < 7; i++) begin
      navigate(0, pairs[i], "A goto pair");
      applyStimulus(0, BS);
      applyStimulus(0, BR); expCol[0]++;
      applyStimulus(0, BS);
      expMapA[pairs[i]*3 +: 6] = 6'd0;
      if (i < 6) begin
        waitState(0, 3'd1, 60, "A pair done");
        checkOutput("A pair removed", 64'(remA), 64'(4 + 2 * i));
      end
    end
    waitState(0, 3'd5, 60, "A enters finish");
    checkOutput("A finish mapReset", 64'(busA.mapReset), 64'd1);
    waitState(0, 3'd0, 60, "A back to gen");
    repeat (2) @(negedge clk);
    checkOutput("A mapReset length", 64'(lastMapA), 64'd15);
    checkOutput("A final removed", 64'(remA), 64'd16);
    checkOutput("A final moves", 64'(movesA), 64'd9);
    checkOutput("A final map", 64'(busA.logicMap), 64'd0);
    checkOutput("A mapReset low", 64'(busA.mapReset), 64'd0);
    expMapA = busA.inputMap;
    loadMap(0);
    checkOutput("A reload moves", 64'(movesA), 64'd0);
    checkOutput("A reload removed", 64'(remA), 64'd0);
    checkOutput("A reload state", 64'(stateA), 64'd1);

    // ---- 5x3 triple game ----
    loadMap(1);
    checkOutput("B loaded state", 64'(stateB), 64'd1);
    setExp(1, 0);
    navigate(1, 4, "B goto 4");
    applyStimulus(1, BR); checkOutput("B 4 right", 64'(cursorB), 64'd0);
    applyStimulus(1, BL); checkOutput("B 0 left", 64'(cursorB), 64'd4);
    applyStimulus(1, BU); checkOutput("B 4 up", 64'(cursorB), 64'd14);
    applyStimulus(1, BD); checkOutput("B 14 down", 64'(cursorB), 64'd4);
    applyStimulus(1, BL); applyStimulus(1, BL);
    checkOutput("B goto 2", 64'(cursorB), 64'd2);
    applyStimulus(1, BU); checkOutput("B 2 up", 64'(cursorB), 64'd12);
    applyStimulus(1, BU | BS);
    checkOutput("B U+S cursor", 64'(cursorB), 64'd12);
    checkOutput("B U+S count", 64'(selCntB), 64'd1);
    setExp(1, 12);
    navigate(1, 13, "B goto 13");
    applyStimulus(1, BS);
    checkOutput("B second count", 64'(selCntB), 64'd2);
    navigate(1, 14, "B goto 14");
    applyStimulus(1, BS);
    waitState(1, 3'd1, 60, "B triple done");
    repeat (2) @(negedge clk);
    expMapB[36 +: 9] = 9'd0;
    checkOutput("B reveal length", 64'(lastRevealB), 64'd20);
    checkOutput("B triple map", 64'(busB.logicMap), 64'(expMapB));
    checkOutput("B triple removed", 64'(remB), 64'd3);
    checkOutput("B triple moves", 64'(movesB), 64'd1);
    checkOutput("B triple slots", 64'(selB), 64'hEDC);
    navigate(1, 0, "B goto 0");
    applyStimulus(1, BS);
    applyStimulus(1, BR); expCol[1]++;
    applyStimulus(1, BS);
    applyStimulus(1, BR); expCol[1]++;
    @(negedge clk);
    btnB = BS;
    waitState(1, 3'd3, 60, "B enters reveal");
    repeat (3) @(negedge clk);
    reset_nB = 1'b0;
    #1;
    checkOutput("B abort state", 64'(stateB), 64'd0);
    checkOutput("B abort cursor", 64'(cursorB), 64'd0);
    checkOutput("B abort count", 64'(selCntB), 64'd0);
    checkOutput("B abort removed", 64'(remB), 64'd0);
    checkOutput("B abort moves", 64'(movesB), 64'd0);
    checkOutput("B abort map", 64'(busB.logicMap), 64'd0);
    checkOutput("B abort mapReset", 64'(busB.mapReset), 64'd0);
    btnB = '0;
    repeat (2) @(negedge clk);
    reset_nB = 1'b1;
    repeat (20) @(negedge clk);
    checkOutput("B waits after abort", 64'(stateB), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
